// File: rtl/seq_shift_add_mult_if.sv
// Start/busy/done handshake and operand/product bus for seq_shift_add_mult.
// The master drives the request and operands; the slave (the multiplier) returns status and product.
interface seq_shift_add_mult_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (output start, output a, output b, input busy, input done, input p);
  modport slave  (input start, input a, input b, output busy, output done, output p);
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier, W x W -> 2W bits, one partial product per clock.
// Define SEQ_SHIFT_ADD_MULT_SIGNED_EN for two's complement operands and product.
module seq_shift_add_mult #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  seq_shift_add_mult_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  // Counter is sized for the widest legal W, so W=1 needs no special case
  localparam logic [4:0] CNT_LAST = 5'(W - 1);

  state_t         r_state;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [4:0]     r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [2*W-1:0] r_p;
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
  logic           r_neg;
`endif

  logic [2*W-1:0] w_sum;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_p_next;

  // Partial-product add, operand magnitudes and final sign fix-up
  always_comb begin
    w_sum = r_acc + (r_mplier[0] ? r_mcand : {(2*W){1'b0}});
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    // |-2^(W-1)| wraps to 2^(W-1), which is still correct as an unsigned W-bit value
    w_a_mag  = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
    w_b_mag  = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;
    w_p_next = r_neg ? (~w_sum + (2*W)'(1)) : w_sum;
`else
    w_a_mag  = bus.a;
    w_b_mag  = bus.b;
    w_p_next = w_sum;
`endif
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_mcand  <= {(2*W){1'b0}};
      r_mplier <= {W{1'b0}};
      r_acc    <= {(2*W){1'b0}};
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= {(2*W){1'b0}};
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_mcand  <= {{W{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= {(2*W){1'b0}};
            r_cnt    <= 5'd0;
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
            r_neg    <= bus.a[W-1] ^ bus.b[W-1];
`endif
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == CNT_LAST) begin
            r_p     <= w_p_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CALC;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.p    = r_p;

endmodule
